// File: rtl/bsg_gw_node_arbiter.sv
// Round-robin scheduler sharing one node channel among local requesters, with
// per-requester credits, tag-routed responses, completion, stall and error flags.
module bsg_gw_node_arbiter #(
  parameter int num_req_p = 4,
  parameter int width_p   = 80,
  parameter int credits_p = 4,
  parameter int timeout_p = 65536,
  parameter int lg_req_lp = $clog2(num_req_p)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [num_req_p-1:0]           req_v_i,
  input  logic [num_req_p*width_p-1:0]   req_data_i,
  output logic [num_req_p-1:0]           req_ready_o,
  output logic                           node_v_o,
  output logic [width_p-1:0]             node_data_o,
  output logic [lg_req_lp-1:0]           node_tag_o,
  input  logic                           node_ready_i,
  input  logic                           resp_v_i,
  input  logic [lg_req_lp-1:0]           resp_tag_i,
  input  logic [width_p-1:0]             resp_data_i,
  output logic                           resp_ready_o,
  output logic [num_req_p-1:0]           resp_v_o,
  output logic [width_p-1:0]             resp_data_o,
  input  logic [num_req_p-1:0]           resp_ready_i,
  input  logic [num_req_p-1:0]           done_i,
  output logic                           all_done_o,
  output logic                           timeout_o,
  output logic                           err_o
);

  localparam int cw = $clog2(credits_p + 1);
  localparam int tw = $clog2(timeout_p + 1);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} phase_e;

  phase_e                phase, phase_next;
  logic [cw-1:0]         credit [num_req_p];
  logic [lg_req_lp-1:0]  rr, winner;
  logic [num_req_p-1:0]  elig, inc, dec;
  logic [width_p-1:0]    sel_data;
  logic [tw-1:0]         idle_cnt, idle_cnt_next;
  logic                  any_elig, grant, tag_ok, resp_hs, all_full, bad_resp;

  always_comb begin
    for (int i = 0; i < num_req_p; i++)
      elig[i] = req_v_i[i] && (credit[i] != '0) && (phase != DONE);
  end

  // Walk downward so the requester closest to rr is the last one written.
  always_comb begin
    int idx;
    idx      = 0;
    winner   = '0;
    any_elig = 1'b0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      idx = (int'(rr) + k) % num_req_p;
      if (elig[lg_req_lp'(idx)]) begin
        winner   = lg_req_lp'(idx);
        any_elig = 1'b1;
      end
    end
  end

  assign grant = any_elig && (!node_v_o || node_ready_i);

  always_comb begin
    req_ready_o = '0;
    sel_data    = '0;
    if (grant) req_ready_o[winner] = 1'b1;
    for (int i = 0; i < num_req_p; i++)
      if (winner == lg_req_lp'(i)) sel_data = req_data_i[i*width_p +: width_p];
  end

  assign tag_ok       = {1'b0, resp_tag_i} < (lg_req_lp + 1)'(num_req_p);
  assign resp_ready_o = tag_ok && resp_ready_i[resp_tag_i];
  assign resp_hs      = resp_v_i && resp_ready_o;
  assign resp_data_o  = resp_data_i;

  always_comb begin
    resp_v_o = '0;
    if (resp_v_i && tag_ok) resp_v_o[resp_tag_i] = 1'b1;
  end

  always_comb begin
    all_full = 1'b1;
    for (int i = 0; i < num_req_p; i++) begin
      inc[i] = resp_hs && (resp_tag_i == lg_req_lp'(i)) && (credit[i] != cw'(credits_p));
      dec[i] = req_ready_o[i];
      if (credit[i] != cw'(credits_p)) all_full = 1'b0;
    end
  end

  assign bad_resp = resp_v_i && (!tag_ok || (resp_hs && credit[resp_tag_i] == cw'(credits_p)));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_req_p; i++) credit[i] <= cw'(credits_p);
      err_o <= 1'b0;
    end else begin
      for (int i = 0; i < num_req_p; i++) begin
        if (inc[i] && !dec[i])      credit[i] <= credit[i] + cw'(1);
        else if (dec[i] && !inc[i]) credit[i] <= credit[i] - cw'(1);
      end
      if (bad_resp) err_o <= 1'b1;
    end
  end

  // Output register: node_v_o is the EMPTY/FULL state; refills in place on a handshake.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      node_v_o    <= 1'b0;
      node_data_o <= '0;
      node_tag_o  <= '0;
      rr          <= '0;
    end else if (grant) begin
      node_v_o    <= 1'b1;
      node_data_o <= sel_data;
      node_tag_o  <= winner;
      rr          <= (winner == lg_req_lp'(num_req_p - 1)) ? '0 : winner + lg_req_lp'(1);
    end else if (node_ready_i) begin
      node_v_o    <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) phase <= RUN;
    else         phase <= phase_next;
  end

  always_comb begin
    phase_next = phase;
    case (phase)
      RUN:     if (&done_i) phase_next = DRAIN;
      DRAIN:   if (!(&done_i)) phase_next = RUN;
               else if (all_full && !node_v_o) phase_next = DONE;
      DONE:    phase_next = DONE;
      default: phase_next = RUN;
    endcase
  end

  assign all_done_o = (phase == DONE);

  always_comb begin
    idle_cnt_next = idle_cnt;
    if (grant || resp_hs || all_full)    idle_cnt_next = '0;
    else if (idle_cnt != tw'(timeout_p)) idle_cnt_next = idle_cnt + tw'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idle_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      idle_cnt <= idle_cnt_next;
      if (idle_cnt_next == tw'(timeout_p)) timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bsg_gw_node_arbiter.sv
// Directed bench for bsg_gw_node_arbiter: arbitration order, backpressure,
// credit accounting, response routing, completion, timeout and async reset.
module tb_bsg_gw_node_arbiter;

  localparam int n = 4;
  localparam int w = 80;

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic [n-1:0]   req_v_i;
  logic [n*w-1:0] req_data_i;
  logic [n-1:0]   req_ready_o;
  logic           node_v_o;
  logic [w-1:0]   node_data_o;
  logic [1:0]     node_tag_o;
  logic           node_ready_i;
  logic           resp_v_i;
  logic [1:0]     resp_tag_i;
  logic [w-1:0]   resp_data_i;
  logic           resp_ready_o;
  logic [n-1:0]   resp_v_o;
  logic [w-1:0]   resp_data_o;
  logic [n-1:0]   resp_ready_i;
  logic [n-1:0]   done_i;
  logic           all_done_o;
  logic           timeout_o;
  logic           err_o;

  int checks = 0;
  int errors = 0;

  bsg_gw_node_arbiter #(
    .num_req_p(n), .width_p(w), .credits_p(4), .timeout_p(16)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_v_i(req_v_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .node_v_o(node_v_o), .node_data_o(node_data_o), .node_tag_o(node_tag_o),
    .node_ready_i(node_ready_i),
    .resp_v_i(resp_v_i), .resp_tag_i(resp_tag_i), .resp_data_i(resp_data_i),
    .resp_ready_o(resp_ready_o), .resp_v_o(resp_v_o), .resp_data_o(resp_data_o),
    .resp_ready_i(resp_ready_i), .done_i(done_i),
    .all_done_o(all_done_o), .timeout_o(timeout_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [w-1:0] pay(int i);
    return 80'hABCD_0000_0000_0000_0000 | 80'(i);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_resp(int tag);
    resp_v_i   = 1'b1;
    resp_tag_i = 2'(tag);
    tick();
    resp_v_i   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_i      = 1'b1;
    req_v_i      = '0;
    node_ready_i = 1'b0;
    resp_v_i     = 1'b0;
    resp_tag_i   = '0;
    resp_data_i  = '0;
    resp_ready_i = '0;
    done_i       = '0;
    for (int i = 0; i < n; i++) req_data_i[i*w +: w] = pay(i);

    tick();
    chk("rst_node_v", node_v_o, 0);
    chk("rst_node_data", node_data_o, 0);
    chk("rst_node_tag", node_tag_o, 0);
    chk("rst_flags", {all_done_o, timeout_o, err_o}, 0);
    tick();
    reset_i = 1'b0;
    tick();

    // Timeout: one outstanding request, no response.
    req_v_i      = 4'b0001;
    node_ready_i = 1'b1;
    #1 chk("to_grant", req_ready_o, 4'b0001);
    tick();
    req_v_i = '0;
    chk("to_node_tag", node_tag_o, 0);
    chk("to_node_data", node_data_o, pay(0));
    repeat (15) tick();
    chk("to_before", timeout_o, 0);
    tick();
    chk("to_at16", timeout_o, 1);

    // Reset mid-packet, with err and timeout set.
    req_v_i      = 4'b0010;
    resp_ready_i = 4'b1111;
    resp_v_i     = 1'b1;
    resp_tag_i   = 2'd2;
    #1 chk("rr_grant1", req_ready_o, 4'b0010);
    tick();
    req_v_i  = '0;
    resp_v_i = 1'b0;
    chk("pre_rst_node_v", node_v_o, 1);
    chk("pre_rst_tag", node_tag_o, 1);
    chk("spurious_err", err_o, 1);
    #3 reset_i = 1'b1;
    #1;
    chk("async_rst_node_v", node_v_o, 0);
    chk("async_rst_flags", {all_done_o, timeout_o, err_o}, 0);
    #2 reset_i = 1'b0;
    tick();

    // Contention: round-robin, four credits each.
    req_v_i = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      #1 chk("cont_ready", req_ready_o, 4'b0001 << (k % 4));
      tick();
      chk("cont_tag", node_tag_o, k % 4);
      chk("cont_data", node_data_o, pay(k % 4));
    end
    #1 chk("cont_exhaust", req_ready_o, 0);
    req_v_i = '0;
    tick();
    chk("cont_drain", node_v_o, 0);

    // Routing: tag 3 with its ready low.
    resp_v_i     = 1'b1;
    resp_tag_i   = 2'd3;
    resp_ready_i = 4'b0111;
    resp_data_i  = 80'hFEED;
    #1;
    chk("route_v", resp_v_o, 4'b1000);
    chk("route_ready", resp_ready_o, 0);
    chk("route_data", resp_data_o, 80'hFEED);
    tick();
    resp_v_i = 1'b0;
    req_v_i  = 4'b1000;
    #1 chk("route_credit3", req_ready_o, 0);
    req_v_i = '0;
    chk("route_err", err_o, 0);

    // Simultaneous issue and response on requester 2 at credit 1.
    resp_ready_i = 4'b1111;
    send_resp(2);
    req_v_i    = 4'b0100;
    resp_v_i   = 1'b1;
    resp_tag_i = 2'd2;
    #1 chk("sim_grant", req_ready_o, 4'b0100);
    chk("sim_resp_ready", resp_ready_o, 1);
    tick();
    resp_v_i = 1'b0;
    #1 chk("sim_credit1", req_ready_o, 4'b0100);
    tick();
    #1 chk("sim_credit0", req_ready_o, 0);
    req_v_i = '0;
    for (int k = 0; k < 4; k++) send_resp(2);
    chk("refill_no_err", err_o, 0);
    send_resp(2);
    chk("overflow_err", err_o, 1);

    // Backpressure.
    node_ready_i = 1'b0;
    req_v_i      = 4'b0100;
    #1 chk("bp_first", req_ready_o, 4'b0100);
    tick();
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_ready", req_ready_o, 0);
      tick();
      chk("bp_hold", {node_v_o, node_tag_o, node_data_o}, {1'b1, 2'd2, pay(2)});
    end
    req_data_i[2*w +: w] = 80'h1234_5678_9ABC_DEF0_0002;
    node_ready_i = 1'b1;
    #1 chk("bp_release", req_ready_o, 4'b0100);
    tick();
    chk("bp_refill", {node_v_o, node_tag_o, node_data_o},
        {1'b1, 2'd2, 80'h1234_5678_9ABC_DEF0_0002});
    req_v_i = '0;
    tick();
    chk("bp_empty", node_v_o, 0);

    // Completion with two outstanding on requester 2.
    for (int k = 0; k < 4; k++) begin
      send_resp(0);
      send_resp(1);
      send_resp(3);
    end
    done_i = 4'b1111;
    tick();
    chk("drain0", all_done_o, 0);
    send_resp(2);
    chk("drain1", all_done_o, 0);
    send_resp(2);
    chk("drain_last", all_done_o, 0);
    tick();
    chk("done_rise", all_done_o, 1);
    done_i = '0;
    tick();
    chk("done_sticky", all_done_o, 1);
    req_v_i = 4'b1111;
    #1 chk("done_no_grant", req_ready_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
